// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin share of one genrom read port (mem_*) between req0/req1 requesters, with ackN grant, validN/dataN/errN response and busy
module rom_port_arbiter #(
  parameter int MEM_ADDR = 5,
  parameter int MEM_EXTRA = 4,
  parameter int DW = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0,
  input  logic                         req1,
  input  logic [MEM_ADDR:0]            addr0,
  input  logic [MEM_ADDR:0]            addr1,
  input  logic [MEM_EXTRA-1:0]         extra0,
  input  logic [MEM_EXTRA-1:0]         extra1,
  input  logic [MEM_ADDR:0]            lb0,
  input  logic [MEM_ADDR:0]            lb1,
  input  logic [MEM_ADDR:0]            ub0,
  input  logic [MEM_ADDR:0]            ub1,
  output logic                         ack0,
  output logic                         ack1,
  output logic                         valid0,
  output logic                         valid1,
  output logic [(2**MEM_EXTRA)*DW-1:0] data0,
  output logic [(2**MEM_EXTRA)*DW-1:0] data1,
  output logic                         err0,
  output logic                         err1,
  output logic [MEM_ADDR:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]         mem_extra,
  output logic [MEM_ADDR:0]            mem_lower_bound,
  output logic [MEM_ADDR:0]            mem_upper_bound,
  input  logic [(2**MEM_EXTRA)*DW-1:0] mem_data,
  input  logic                         mem_error,
  output logic                         busy
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic       last_grant, gnt, win;
  always_comb win = (req0 && req1) ? ~last_grant : req1;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b1;
      gnt <= 1'b0;
      {ack0, ack1, valid0, valid1, err0, err1} <= '0;
      data0 <= '0;
      data1 <= '0;
      mem_addr <= '0;
      mem_extra <= '0;
      mem_lower_bound <= '0;
      mem_upper_bound <= '1;
    end else begin
      {ack0, ack1, valid0, valid1} <= '0;
      if (state == IDLE && (req0 || req1)) begin
        ack0 <= ~win;
        ack1 <= win;
        mem_addr <= win ? addr1 : addr0;
        mem_extra <= win ? extra1 : extra0;
        mem_lower_bound <= win ? lb1 : lb0;
        mem_upper_bound <= win ? ub1 : ub0;
        last_grant <= win;
        gnt <= win;
        cnt <= 4'(ROM_LATENCY);
        state <= WAIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        state <= cnt == 4'd1 ? RESP : WAIT;
      end else if (state == RESP) begin
        if (gnt) {data1, err1, valid1} <= {mem_data, mem_error, 1'b1};
        else {data0, err0, valid0} <= {mem_data, mem_error, 1'b1};
        state <= IDLE;
      end
    end
endmodule
